// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: two-stage pipelined LEGv8 immediate extractor/extender.
// Stage 1 latches the decoded format, the raw immediate field (right-aligned)
// and the MOVZ hw field. Stage 2 latches the extended/shifted immediate and
// drives the outputs directly. Valid/ready handshake on both sides, no skid.
module imm_ext_pipe #(
    parameter int DATA_W   = 64,    // 32 or 64
    parameter bit SHIFT_BR = 1'b1   // scale CB/B offsets to byte offsets
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [2:0]        out_fmt,
    output logic              out_illegal
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_D    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_B    = 3'd3,
        FMT_I    = 3'd4,
        FMT_IM   = 3'd5
    } fmt_e;

    // Opcode table on instr[31:21]: a pattern hits when the cared-for bits
    // match. The patterns are mutually exclusive, so at most one hits.
    localparam int N_PAT = 10;
    localparam logic [10:0] PAT_VAL [N_PAT] = '{
        11'b11111000010,    // LDUR
        11'b11111000000,    // STUR
        11'b10110100000,    // CBZ
        11'b10110101000,    // CBNZ
        11'b00010100000,    // B
        11'b10010001000,    // ADDI
        11'b10010010000,    // ANDI
        11'b10110010000,    // ORRI
        11'b11010001000,    // SUBI
        11'b11010010100     // MOVZ
    };
    localparam logic [10:0] PAT_CARE [N_PAT] = '{
        11'b11111111111,
        11'b11111111111,
        11'b11111111000,
        11'b11111111000,
        11'b11111100000,
        11'b11111111110,
        11'b11111111110,
        11'b11111111110,
        11'b11111111110,
        11'b11111111100
    };
    localparam fmt_e PAT_FMT [N_PAT] = '{
        FMT_D, FMT_D, FMT_CB, FMT_CB, FMT_B,
        FMT_I, FMT_I, FMT_I, FMT_I, FMT_IM
    };

    // MOVZ with hw >= 2 cannot be represented in a 32-bit result.
    localparam bit NARROW = (DATA_W == 32);

    // Pipeline state
    logic              s1_valid_reg;
    fmt_e              s1_fmt_reg;
    logic [25:0]       s1_raw_reg;
    logic [1:0]        s1_hw_reg;

    logic              s2_valid_reg;
    logic [DATA_W-1:0] s2_imm_reg;
    fmt_e              s2_fmt_reg;
    logic              s2_ill_reg;

    // Next-state values
    fmt_e              s1_fmt_next;
    logic [25:0]       s1_raw_next;
    logic [1:0]        s1_hw_next;
    logic [63:0]       ext_wide;
    logic [DATA_W-1:0] s2_imm_next;
    logic              s2_ill_next;

    // Handshake: a stage loads when it is empty or its contents move on.
    logic s1_load;
    logic s2_load;

    assign s2_load  = !s2_valid_reg || out_ready;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = s1_load;

    // One match comparator per opcode pattern.
    logic [N_PAT-1:0] pat_hit;
    genvar gi;
    generate
        for (gi = 0; gi < N_PAT; gi++) begin : g_pat
            assign pat_hit[gi] = ((in_instr[31:21] & PAT_CARE[gi]) == PAT_VAL[gi]);
        end
    endgenerate

    // Select the format of whichever pattern hit (none -> R/none).
    always_comb begin
        s1_fmt_next = FMT_NONE;
        for (int i = 0; i < N_PAT; i++) begin
            if (pat_hit[i]) begin
                s1_fmt_next = PAT_FMT[i];
            end
        end
    end

    // Pick the raw immediate field for the decoded format, right-aligned.
    always_comb begin
        s1_raw_next = '0;
        case (s1_fmt_next)
            FMT_D:   s1_raw_next = {17'd0, in_instr[20:12]};
            FMT_CB:  s1_raw_next = {7'd0, in_instr[23:5]};
            FMT_B:   s1_raw_next = in_instr[25:0];
            FMT_I:   s1_raw_next = {14'd0, in_instr[21:10]};
            FMT_IM:  s1_raw_next = {10'd0, in_instr[20:5]};
            default: s1_raw_next = '0;
        endcase
    end

    assign s1_hw_next = in_instr[22:21];

    // Stage 1 register: captures the decoded instruction when it is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_fmt_reg   <= FMT_NONE;
            s1_raw_reg   <= '0;
            s1_hw_reg    <= '0;
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_fmt_reg <= s1_fmt_next;
                s1_raw_reg <= s1_raw_next;
                s1_hw_reg  <= s1_hw_next;
            end
        end
    end

    // Extension and shifting done at 64 bits, then truncated to DATA_W so
    // anything shifted above the output width is simply dropped.
    always_comb begin
        ext_wide    = '0;
        s2_ill_next = 1'b0;
        case (s1_fmt_reg)
            FMT_D: begin
                ext_wide = {{55{s1_raw_reg[8]}}, s1_raw_reg[8:0]};
            end
            FMT_CB: begin
                ext_wide = {{45{s1_raw_reg[18]}}, s1_raw_reg[18:0]};
                if (SHIFT_BR) begin
                    ext_wide = ext_wide << 2;
                end
            end
            FMT_B: begin
                ext_wide = {{38{s1_raw_reg[25]}}, s1_raw_reg[25:0]};
                if (SHIFT_BR) begin
                    ext_wide = ext_wide << 2;
                end
            end
            FMT_I: begin
                ext_wide = {52'd0, s1_raw_reg[11:0]};
            end
            FMT_IM: begin
                if (NARROW && s1_hw_reg[1]) begin
                    s2_ill_next = 1'b1;
                end else begin
                    ext_wide = {48'd0, s1_raw_reg[15:0]} << {s1_hw_reg, 4'b0000};
                end
            end
            default: begin
                ext_wide = '0;
            end
        endcase
    end

    assign s2_imm_next = ext_wide[DATA_W-1:0];

    // Stage 2 register: holds the finished result; it stays put while the
    // consumer stalls, and keeps its last value across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_reg <= 1'b0;
            s2_imm_reg   <= '0;
            s2_fmt_reg   <= FMT_NONE;
            s2_ill_reg   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_imm_reg <= s2_imm_next;
                s2_fmt_reg <= s1_fmt_reg;
                s2_ill_reg <= s2_ill_next;
            end
        end
    end

    assign out_valid   = s2_valid_reg;
    assign out_imm     = s2_imm_reg;
    assign out_fmt     = s2_fmt_reg;
    assign out_illegal = s2_ill_reg;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: bench for imm_ext_pipe. Three instances share one stimulus:
// DATA_W=64/SHIFT_BR=1, DATA_W=32/SHIFT_BR=1 and DATA_W=64/SHIFT_BR=0.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;

    logic        in_ready_32, out_valid_32, out_illegal_32;
    logic [31:0] out_imm_32;
    logic [2:0]  out_fmt_32;

    logic        in_ready_nb, out_valid_nb, out_illegal_nb;
    logic [63:0] out_imm_nb;
    logic [2:0]  out_fmt_nb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imm_ext_pipe #(.DATA_W(64), .SHIFT_BR(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    imm_ext_pipe #(.DATA_W(32), .SHIFT_BR(1'b1)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_32),
        .in_instr(in_instr), .out_valid(out_valid_32), .out_ready(out_ready),
        .out_imm(out_imm_32), .out_fmt(out_fmt_32), .out_illegal(out_illegal_32)
    );

    imm_ext_pipe #(.DATA_W(64), .SHIFT_BR(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_nb),
        .in_instr(in_instr), .out_valid(out_valid_nb), .out_ready(out_ready),
        .out_imm(out_imm_nb), .out_fmt(out_fmt_nb), .out_illegal(out_illegal_nb)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sign-extend a w-bit field held in f.
    function automatic longint sext(input longint f, input int w);
        return f[w-1] ? f - (longint'(1) << w) : f;
    endfunction

    // Reference model: immediate, format and illegal flag straight from the
    // instruction-level rules.
    function automatic void model(input logic [31:0] ins, input int dw, input bit shbr,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic ill);
        longint v;
        int     hw;
        v   = 0;
        fmt = 3'd0;
        ill = 1'b0;
        hw  = int'(ins[22:21]);
        casez (ins[31:21])
            11'b11111000010, 11'b11111000000: begin
                fmt = 3'd1;
                v   = sext(longint'(ins[20:12]), 9);
            end
            11'b10110100???, 11'b10110101???: begin
                fmt = 3'd2;
                v   = sext(longint'(ins[23:5]), 19);
                if (shbr) v = v * 4;
            end
            11'b000101?????: begin
                fmt = 3'd3;
                v   = sext(longint'(ins[25:0]), 26);
                if (shbr) v = v * 4;
            end
            11'b1001000100?, 11'b1001001000?, 11'b1011001000?, 11'b1101000100?: begin
                fmt = 3'd4;
                v   = longint'(ins[21:10]);
            end
            11'b110100101??: begin
                fmt = 3'd5;
                if (dw == 32 && hw >= 2) begin
                    ill = 1'b1;
                    v   = 0;
                end else begin
                    v = longint'(ins[20:5]) * (longint'(1) << (16 * hw));
                end
            end
            default: ;
        endcase
        if (dw == 32) v = v & 64'hFFFF_FFFF;
        imm = 64'(v);
    endfunction

    // Random instruction, biased towards the recognised opcode classes.
    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [10:0] p, c;
        int k;
        r = $urandom;
        k = $urandom_range(0, 10);
        case (k)
            0:       begin p = 11'b11111000010; c = 11'b11111111111; end
            1:       begin p = 11'b11111000000; c = 11'b11111111111; end
            2:       begin p = 11'b10110100000; c = 11'b11111111000; end
            3:       begin p = 11'b10110101000; c = 11'b11111111000; end
            4:       begin p = 11'b00010100000; c = 11'b11111100000; end
            5:       begin p = 11'b10010001000; c = 11'b11111111110; end
            6:       begin p = 11'b10010010000; c = 11'b11111111110; end
            7:       begin p = 11'b10110010000; c = 11'b11111111110; end
            8:       begin p = 11'b11010001000; c = 11'b11111111110; end
            9:       begin p = 11'b11010010100; c = 11'b11111111100; end
            default: begin p = 11'b0;           c = 11'b0;           end
        endcase
        return {p | (r[31:21] & ~c), r[20:0]};
    endfunction

    // Scoreboard: accepted instructions in order; also checks output stability
    // while the consumer stalls. Runs on the falling edge when inputs are stable.
    logic [31:0] sb_q[$];
    bit          sb_en = 1'b0;
    bit          hold_vld = 1'b0;
    logic [63:0] hold_imm;

    initial begin
        logic [31:0] ins;
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb_q.delete();
                hold_vld = 1'b0;
            end else begin
                if (hold_vld) begin
                    chk("stall_valid", 64'(out_valid), 64'd1);
                    chk("stall_hold", out_imm, hold_imm);
                end
                hold_vld = out_valid && !out_ready;
                hold_imm = out_imm;
                if (sb_en && out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("spurious_out", 64'(out_valid), 64'd0);
                    end else begin
                        ins = sb_q.pop_front();
                        $display("[TB] out instr=%08h imm=%016h fmt=%0d ill=%0b", ins, out_imm, out_fmt, out_illegal);
                        model(ins, 64, 1'b1, e_imm, e_fmt, e_ill);
                        chk("sb_imm64", out_imm, e_imm);
                        chk("sb_fmt64", 64'(out_fmt), 64'(e_fmt));
                        chk("sb_ill64", 64'(out_illegal), 64'(e_ill));
                        model(ins, 32, 1'b1, e_imm, e_fmt, e_ill);
                        chk("sb_valid32", 64'(out_valid_32), 64'd1);
                        chk("sb_imm32", 64'(out_imm_32), e_imm);
                        chk("sb_fmt32", 64'(out_fmt_32), 64'(e_fmt));
                        chk("sb_ill32", 64'(out_illegal_32), 64'(e_ill));
                        model(ins, 64, 1'b0, e_imm, e_fmt, e_ill);
                        chk("sb_valid_nb", 64'(out_valid_nb), 64'd1);
                        chk("sb_imm_nb", out_imm_nb, e_imm);
                    end
                end
                if (sb_en && in_valid && in_ready) begin
                    sb_q.push_back(in_instr);
                end
            end
        end
    end

    // Directed vectors with hand-computed expectations for all three configs.
    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm64;
        logic [31:0] imm32;
        logic [63:0] imm_nb;
        logic [2:0]  fmt;
        logic        ill32;
    } vec_t;

    vec_t vecs[13];
    bit   exp_rdy[12]  = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    bit   exp_emit[12] = '{0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int seen;
        bit acc;
        logic [31:0] bp_list[5];

        vecs[0]  = '{32'hF85FF000, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
        vecs[1]  = '{32'hD2E24680, 64'h1234000000000000, 32'h00000000, 64'h1234000000000000, 3'd5, 1'b1};
        vecs[2]  = '{32'h17FFFFFF, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFF, 3'd3, 1'b0};
        vecs[3]  = '{32'h913FFC00, 64'h0000000000000FFF, 32'h00000FFF, 64'h0000000000000FFF, 3'd4, 1'b0};
        vecs[4]  = '{32'h8B000000, 64'h0,                32'h0,        64'h0,                3'd0, 1'b0};
        vecs[5]  = '{32'hB4000041, 64'h8,                32'h8,        64'h2,                3'd2, 1'b0};
        vecs[6]  = '{32'hB5FFFFE0, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFF, 3'd2, 1'b0};
        vecs[7]  = '{32'hF8010000, 64'h10,               32'h10,       64'h10,               3'd1, 1'b0};
        vecs[8]  = '{32'hD2A00020, 64'h10000,            32'h10000,    64'h10000,            3'd5, 1'b0};
        vecs[9]  = '{32'hB2000C00, 64'h3,                32'h3,        64'h3,                3'd4, 1'b0};
        vecs[10] = '{32'hD1400000, 64'h0,                32'h0,        64'h0,                3'd0, 1'b0};
        vecs[11] = '{32'hD2C00020, 64'h100000000,        32'h0,        64'h100000000,        3'd5, 1'b1};
        vecs[12] = '{32'h14000010, 64'h40,               32'h40,       64'h10,               3'd3, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_imm", out_imm, 64'd0);
        chk("rst_out_fmt", 64'(out_fmt), 64'd0);
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors, one at a time, checking the exact latency
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("vec_latency_early", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
            $display("[TB] vec %0d instr=%08h imm=%016h fmt=%0d imm32=%08h ill32=%0b imm_nb=%016h",
                     i, vecs[i].instr, out_imm, out_fmt, out_imm_32, out_illegal_32, out_imm_nb);
            chk("vec_out_valid", 64'(out_valid), 64'd1);
            chk("vec_imm64", out_imm, vecs[i].imm64);
            chk("vec_fmt", 64'(out_fmt), 64'(vecs[i].fmt));
            chk("vec_ill64", 64'(out_illegal), 64'd0);
            chk("vec_imm32", 64'(out_imm_32), 64'(vecs[i].imm32));
            chk("vec_fmt32", 64'(out_fmt_32), 64'(vecs[i].fmt));
            chk("vec_ill32", 64'(out_illegal_32), 64'(vecs[i].ill32));
            chk("vec_imm_nb", out_imm_nb, vecs[i].imm_nb);
        end
        @(posedge clk);
        #1;

        // Backpressure: five back-to-back instructions, consumer stalls cycles 3-6
        sb_en = 1'b1;
        foreach (bp_list[i]) bp_list[i] = rand_instr();
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (idx < 5);
            in_instr  = (idx < 5) ? bp_list[idx] : 32'h0;
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'(exp_rdy[c]));
            chk("bp_emit", 64'(out_valid && out_ready), 64'(exp_emit[c]));
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
        end
        chk("bp_all_accepted", 64'(idx), 64'd5);
        chk("bp_queue_empty", 64'(sb_q.size()), 64'd0);

        // Reset with both stages full: nothing from before the reset may emerge
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hF85FF000;
        @(posedge clk);
        #1;
        in_instr  = 32'hD2E24680;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("rst_pre_full", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_out_imm", out_imm, 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        reset     = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        chk("rst_no_stale", 64'(seen), 64'd0);

        // Random traffic against the reference model
        in_valid = 1'b0;
        acc      = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 99) < 70);
                in_instr = rand_instr();
            end
            out_ready = ($urandom_range(0, 99) < 70);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
        end

        // Drain
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("drain_queue_empty", 64'(sb_q.size()), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Pipelined, parametrised successor to the combinational immediate sign-extender.
- Accepts one 32-bit LEGv8 instruction per cycle over a valid/ready handshake.
- Decodes the immediate format and produces a DATA_W-bit extended immediate plus a format tag, two cycles later.
- Adds MOVZ half-word shift (hw field), optional branch-offset scaling, an illegal-format flag, and backpressure.
- Sits between fetch and the register-read/ALU stages of the pipelined core.

Parameters:
- DATA_W, 64: output immediate width. Legal values: 32 or 64.
- SHIFT_BR, 1: when 1, CB/B offsets are scaled left by 2 (byte offsets); when 0, they are raw word offsets.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present on in_instr.
- in_ready  out  1  block accepts the instruction this cycle.
- in_instr  in  32  instruction word.
- out_valid  out  1  out_imm, out_fmt and out_illegal are valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_imm  out  DATA_W  extended immediate.
- out_fmt  out  3  format: 0=R/none, 1=D, 2=CB, 3=B, 4=I, 5=IM.
- out_illegal  out  1  MOVZ hw not representable in DATA_W.

Behaviour:
- Opcode match on instr[31:21] (? = don't care):
  - LDUR 11111000010, STUR 11111000000 -> D
  - CBZ 10110100???, CBNZ 10110101??? -> CB
  - B 000101????? -> B
  - ADDI 1001000100?, ANDI 1001001000?, ORRI 1011001000?, SUBI 1101000100? -> I
  - MOVZ 110100101?? -> IM
  - anything else -> fmt 0, imm 0.
- Extension rules:
  - D: sign-extend instr[20:12].
  - CB: sign-extend instr[23:5].
  - B: sign-extend instr[25:0].
  - CB/B with SHIFT_BR=1: shift left 2 after extension; bits shifted out above DATA_W are discarded.
  - I: zero-extend instr[21:10].
  - IM: zero-extend instr[20:5], then shift left by 16*instr[22:21].
  - IM with DATA_W=32 and hw>=2: imm=0, out_illegal=1.
  - out_illegal is 0 in all other cases.
- Stage 1 register: opcode class, raw field, hw.
- Stage 2 register: extension/shift result. Stage 2 drives the outputs directly (registered outputs).
- Latency: 2 cycles from the accepting edge (in_valid & in_ready) to out_valid, with no stalls. Throughput: 1 instruction per cycle.
- Handshake rules:
  - s2 loads when !s2_valid or out_ready.
  - s1 loads when !s1_valid or s2 loads.
  - in_ready = !s1_valid or s2 loads. This is combinational from out_ready; the block provides no skid buffer.
  - Outputs hold stable while out_valid & !out_ready.
  - A transfer occurs only on valid & ready at the same edge.
- Simultaneous events:
  - Accept and emit in the same cycle is legal. s1 moves to s2 and the new instruction enters s1 on the same edge.
  - Full (s1 & s2 valid, out_ready=0): in_ready=0; no data is lost or overwritten.
- Reset:
  - Clears s1_valid and s2_valid.
  - Zeroes out_imm, out_fmt and out_illegal.
  - out_valid=0; in_ready=1 on the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight instructions; nothing is emitted afterwards for them.
- No state beyond the two pipeline registers.

Test Plan:
- LDUR 0xF85FF000, DATA_W=64 -> 2 cycles later: out_imm=0xFFFFFFFFFFFFFFFF, out_fmt=1, out_illegal=0.
- MOVZ 0xD2E24680 (hw=3, imm16=0x1234) -> out_imm=0x1234000000000000, fmt=5. Same instruction with DATA_W=32 -> out_imm=0, out_illegal=1.
- B 0x17FFFFFF: SHIFT_BR=1 -> out_imm=0xFFFFFFFFFFFFFFFC; SHIFT_BR=0 -> 0xFFFFFFFFFFFFFFFF. ADDI 0x913FFC00 -> out_imm=0xFFF, fmt=4.
- Backpressure:
  - Stimulus: stream 5 instructions back-to-back with out_ready=0 for cycles 3-6.
  - in_ready drops once both stages are full.
  - out_imm holds stable while stalled.
  - All 5 results emerge in order with no duplicates or drops.
  - Full throughput of 1/cycle resumes once out_ready=1.
- Reset mid-stream: assert reset with both stages valid -> next cycle out_valid=0, out_imm=0, in_ready=1; no stale output is emitted afterwards.
- Unknown opcode 0x8B000000 (ADD, R-format) -> out_imm=0, out_fmt=0, out_illegal=0, latency 2.
